// File: rtl/learn_sequencer.sv
// learn_sequencer: guided "play the song" lesson controller.
// Walks a song ROM note by note, shows the expected note as a hint, waits for
// the player's key, gives a timed buzz as feedback and keeps score. A note is
// skipped after RETRY_MAX misses; the lesson ends on the END code (all-ones)
// or after the last addressable note of the song, and a 0..3 grade is shown.
module learn_sequencer #(
    parameter int NOTE_W      = 4,
    parameter int SONG_W      = 3,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int BUZZ_CYC    = 10_000_000,
    parameter int RETRY_MAX   = 3,
    parameter int SCORE_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SONG_W-1:0]          song_sel,
    input  logic                       start,
    input  logic                       back,
    input  logic                       key_valid,
    input  logic [NOTE_W-1:0]          key_note,
    output logic [SONG_W+ADDR_W-1:0]   rom_addr,
    input  logic [NOTE_W-1:0]          rom_data,
    output logic [NOTE_W-1:0]          hint_note,
    output logic                       hint_valid,
    output logic                       buzz_on,
    output logic [NOTE_W-1:0]          buzz_note,
    output logic                       correct,
    output logic                       wrong,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         miss_total,
    output logic [SCORE_W-1:0]         note_count,
    output logic [1:0]                 grade,
    output logic                       done,
    output logic [2:0]                 state
);

    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BUZZ_W  = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_CYC - 1);
    localparam logic [3:0]         RETRY_LAST = 4'(RETRY_MAX - 1);
    localparam logic [NOTE_W-1:0]  NOTE_END   = {NOTE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_SAT  = {SCORE_W{1'b1}};
    localparam logic [ADDR_W-1:0]  INDEX_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_WAIT_KEY = 3'd3,
        S_FEEDBACK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                      state_reg;
    logic [SONG_W-1:0]           song_reg;
    logic [ADDR_W-1:0]           index_reg;
    logic                        at_end_reg;   // index already advanced past the last slot
    logic                        advance_reg;  // the note just judged moves the lesson on
    logic [SONG_W+ADDR_W-1:0]    rom_addr_reg;
    logic [NOTE_W-1:0]           hint_note_reg;
    logic                        hint_valid_reg;
    logic [TIMER_W-1:0]          timer_reg;
    logic [3:0]                  retry_reg;
    logic                        buzz_on_reg;
    logic [NOTE_W-1:0]           buzz_note_reg;
    logic [BUZZ_W-1:0]           buzz_cnt_reg;
    logic                        correct_reg;
    logic                        wrong_reg;
    logic [SCORE_W-1:0]          score_reg;
    logic [SCORE_W-1:0]          miss_reg;
    logic [SCORE_W-1:0]          count_reg;
    logic [1:0]                  grade_reg;
    logic                        done_reg;

    logic                        key_match;
    logic                        timed_out;
    logic                        last_try;
    logic [SCORE_W-1:0]          score_inc;
    logic [SCORE_W-1:0]          miss_inc;
    logic [SCORE_W-1:0]          count_inc;
    logic [1:0]                  grade_calc;

    // Per-cycle judgement of the current note, saturating counter steps and
    // the grade that would be shown if the lesson ended now.
    always_comb begin
        key_match = (key_note == hint_note_reg);
        // A key in the same cycle as the timeout wins: the timeout is dropped.
        timed_out = !key_valid && (timer_reg == TIMER_LAST);
        last_try  = (retry_reg == RETRY_LAST);
        score_inc = (score_reg == SCORE_SAT) ? score_reg : score_reg + SCORE_W'(1);
        miss_inc  = (miss_reg  == SCORE_SAT) ? miss_reg  : miss_reg  + SCORE_W'(1);
        count_inc = (count_reg == SCORE_SAT) ? count_reg : count_reg + SCORE_W'(1);
        if (miss_reg == '0) begin
            grade_calc = 2'd3;
        end else if (miss_reg <= (count_reg >> 2)) begin
            grade_calc = 2'd2;
        end else if (score_reg != '0) begin
            grade_calc = 2'd1;
        end else begin
            grade_calc = 2'd0;
        end
    end

    // Lesson state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            song_reg       <= '0;
            index_reg      <= '0;
            at_end_reg     <= 1'b0;
            advance_reg    <= 1'b0;
            rom_addr_reg   <= '0;
            hint_note_reg  <= '0;
            hint_valid_reg <= 1'b0;
            timer_reg      <= '0;
            retry_reg      <= '0;
            buzz_on_reg    <= 1'b0;
            buzz_note_reg  <= '0;
            buzz_cnt_reg   <= '0;
            correct_reg    <= 1'b0;
            wrong_reg      <= 1'b0;
            score_reg      <= '0;
            miss_reg       <= '0;
            count_reg      <= '0;
            grade_reg      <= '0;
            done_reg       <= 1'b0;
        end else begin
            correct_reg <= 1'b0;
            wrong_reg   <= 1'b0;
            if (back) begin
                // Abort: drop the visible indicators, keep the counters for review.
                state_reg      <= S_IDLE;
                buzz_on_reg    <= 1'b0;
                hint_valid_reg <= 1'b0;
                done_reg       <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            song_reg     <= song_sel;
                            index_reg    <= '0;
                            at_end_reg   <= 1'b0;
                            advance_reg  <= 1'b0;
                            retry_reg    <= '0;
                            score_reg    <= '0;
                            miss_reg     <= '0;
                            count_reg    <= '0;
                            grade_reg    <= '0;
                            done_reg     <= 1'b0;
                            rom_addr_reg <= {song_sel, {ADDR_W{1'b0}}};
                            state_reg    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Address is already on rom_addr; ROM answers next cycle.
                        state_reg <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (rom_data == NOTE_END) begin
                            done_reg  <= 1'b1;
                            grade_reg <= grade_calc;
                            state_reg <= S_DONE;
                        end else begin
                            hint_note_reg  <= rom_data;
                            hint_valid_reg <= 1'b1;
                            timer_reg      <= '0;
                            state_reg      <= S_WAIT_KEY;
                        end
                    end
                    S_WAIT_KEY: begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                        if (key_valid || timed_out) begin
                            hint_valid_reg <= 1'b0;
                            buzz_on_reg    <= 1'b1;
                            buzz_cnt_reg   <= '0;
                            buzz_note_reg  <= key_valid ? key_note : hint_note_reg;
                            state_reg      <= S_FEEDBACK;
                            if (key_valid && key_match) begin
                                correct_reg <= 1'b1;
                                score_reg   <= score_inc;
                                count_reg   <= count_inc;
                                retry_reg   <= '0;
                                advance_reg <= 1'b1;
                                if (index_reg == INDEX_LAST) begin
                                    at_end_reg <= 1'b1;
                                end else begin
                                    index_reg <= index_reg + ADDR_W'(1);
                                end
                            end else begin
                                wrong_reg <= 1'b1;
                                miss_reg  <= miss_inc;
                                if (last_try) begin
                                    // Out of retries: count the note and move on.
                                    count_reg   <= count_inc;
                                    retry_reg   <= '0;
                                    advance_reg <= 1'b1;
                                    if (index_reg == INDEX_LAST) begin
                                        at_end_reg <= 1'b1;
                                    end else begin
                                        index_reg <= index_reg + ADDR_W'(1);
                                    end
                                end else begin
                                    retry_reg   <= retry_reg + 4'd1;
                                    advance_reg <= 1'b0;
                                end
                            end
                        end
                    end
                    S_FEEDBACK: begin
                        if (buzz_cnt_reg == BUZZ_LAST) begin
                            buzz_on_reg <= 1'b0;
                            if (!advance_reg) begin
                                timer_reg      <= '0;
                                hint_valid_reg <= 1'b1;
                                state_reg      <= S_WAIT_KEY;
                            end else if (at_end_reg) begin
                                // Song had no END within its address range.
                                done_reg  <= 1'b1;
                                grade_reg <= grade_calc;
                                state_reg <= S_DONE;
                            end else begin
                                rom_addr_reg <= {song_reg, index_reg};
                                state_reg    <= S_FETCH;
                            end
                        end else begin
                            buzz_cnt_reg <= buzz_cnt_reg + BUZZ_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = rom_addr_reg;
    assign hint_note  = hint_note_reg;
    assign hint_valid = hint_valid_reg;
    assign buzz_on    = buzz_on_reg;
    assign buzz_note  = buzz_note_reg;
    assign correct    = correct_reg;
    assign wrong      = wrong_reg;
    assign score      = score_reg;
    assign miss_total = miss_reg;
    assign note_count = count_reg;
    assign grade      = grade_reg;
    assign done       = done_reg;
    assign state      = state_reg;

endmodule
